ex3_to_bcd_stream: RTL and testbench
====================================

// Module: ex3_to_bcd_stream
// PURPOSE
//  Decodes a serial stream of Excess-3 digits back to BCD (digit = code - 3).
//  Packs NDIG consecutive digits, most-significant first, into one BCD word.
//  Flags invalid Excess-3 codes on the way.
//  Sits on the receive side of the Excess-3 link, behind the BCD->Excess-3 encoder path.
// PARAMETERS
//  NDIG  4  digits per output word (>=1); out_data width = 4*NDIG
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  clr        in   1       sync flush of partial word / held word
//  in_valid   in   1       in_ex3 valid
//  in_ready   out  1       decoder can accept a digit
//  in_ex3     in   4       Excess-3 digit code
//  out_valid  out  1       packed BCD word valid
//  out_ready  in   1       downstream accepts word
//  out_data   out  4*NDIG  packed BCD, first-received digit in MS nibble
//  out_err    out  1       word contains >=1 substituted invalid digit
//  bad_digit  out  1       1-cycle pulse: invalid code accepted this cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): state=COLLECT, cnt=0, out_data=0, out_valid=0,
//   out_err=0, bad_digit=0, in_ready=1 after release.
//  Transfer on an edge with valid&ready high on the same side.
//  Valid codes: 4'b0011..4'b1100; bcd = in_ex3 - 4'd3 (4-bit, no carry out).
//  Invalid codes: 0000-0010 and 1101-1111.
//  FSM COLLECT: in_ready=1, out_valid=0.
//   Each accepted digit: shift reg <= {reg[4*NDIG-5:0], bcd}; cnt++.
//   Accept when cnt==NDIG-1 -> cnt=0, go HOLD.
//   out_valid rises the next cycle (latency 1 from last digit).
//  FSM HOLD: in_ready=0, out_valid=1.
//   out_data and out_err stay stable until out_ready.
//   On out_ready -> COLLECT, out_err cleared.
//   No same-cycle in/out overlap; max throughput 1 word per NDIG+1 cycles.
//  out_data holds the last word after handoff; it is only meaningful while out_valid=1.
//  bad_digit: registered; high the cycle after an invalid code is accepted.
//  Boundaries:
//   clr=1: state=COLLECT, cnt=0, out_valid=0 and out_err=0 next cycle.
//    clr wins over a same-cycle in/out transfer: the digit is dropped and bad_digit is not set.
//   in_valid with in_ready=0: digit is not consumed; the source must hold it.
//   NDIG=1: every accepted digit goes straight to HOLD.
//   Async reset mid-word or mid-HOLD: the partial or held word is discarded.
//   No output pulse is generated for discarded data.
// CONFIGURATION
//  Macro EX3_DROP_INVALID_EN:
//   Undefined: invalid digit is shifted in as 4'hF, cnt advances, out_err=1 for that word.
//   Defined: invalid digit is accepted and discarded; cnt and the shift reg are unchanged.
//    out_err is tied 0.
//  bad_digit pulses in both modes.
// TESTING
//  1 reset: rst_n=0 -> out_valid=0, out_data=16'h0000, in_ready=1 after release.
//  2 digits 4'h4,4'h6,4'h8,4'hC back-to-back -> out_valid 1 cycle after 4th digit,
//    out_data=16'h1359, out_err=0.
//  3 backpressure: word 16'h1359 held with out_ready=0 for 5 cycles -> in_ready=0,
//    out_data stable; out_ready=1 -> in_ready=1 next cycle.
//  4 invalid: 4'h4,4'h1,4'h8,4'hC -> bad_digit pulse, out_data=16'h1F59, out_err=1.
//    With EX3_DROP_INVALID_EN, then send 4'h3 -> out_data=16'h1590, out_err=0.
//  5 rst_n low after 2 digits, then 4'hC,4'hC,4'h3,4'h3 -> out_data=16'h9900.
//  6 clr with in_valid on the 3rd digit, then 4 more digits -> only the last 4 form the word.
//    Repeat with clr during HOLD -> out_valid drops next cycle.

Source files
------------

// File: rtl/ex3_to_bcd_stream.sv
// Excess-3 digit stream to packed BCD words (NDIG digits, first digit in MS nibble); word valid 1 cycle after last digit,
// input stalls (in_ready=0) while a word is held for out_ready. EX3_DROP_INVALID_EN: discard bad codes instead of substituting 4'hF.
module ex3_to_bcd_stream #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ex3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic              out_err,
  output logic              bad_digit
);

  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  data_q, data_d;
  logic          bad_q, bad_d;

  logic          code_ok;
  logic [3:0]    bcd;
  logic          in_fire;
  logic          take;
  logic          last_dig;
  logic [W+3:0]  shift_w;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign bad_digit = bad_q;

  assign code_ok  = (in_ex3 >= 4'd3) && (in_ex3 <= 4'd12);
  assign bcd      = code_ok ? (in_ex3 - 4'd3) : 4'hF;
  assign in_fire  = in_valid && in_ready;
  assign shift_w  = {data_q, bcd};
  assign last_dig = (cnt_q == CW'(NDIG - 1));

`ifdef EX3_DROP_INVALID_EN
  // Invalid codes are consumed but leave the word untouched.
  assign take = in_fire && code_ok;
`else
  assign take = in_fire;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    bad_d   = 1'b0;
    if (clr) begin
      // Flush wins over any same-cycle transfer; the offered digit is dropped.
      state_d = COLLECT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_fire) begin
            bad_d = !code_ok;
          end
          if (take) begin
            data_d = shift_w[W-1:0];
            if (last_dig) begin
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = COLLECT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      data_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      bad_q   <= bad_d;
    end
  end

`ifdef EX3_DROP_INVALID_EN
  assign out_err = 1'b0;
`else
  logic err_q, err_d;

  // Sticky per word: set by any substituted digit, cleared on handoff or flush.
  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = 1'b0;
    end else if (state_q == HOLD) begin
      if (out_ready) begin
        err_d = 1'b0;
      end
    end else if (take && !code_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = err_q && (state_q == HOLD);
`endif

  // A held word must not change until it is taken or flushed.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !clr) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_ex3_to_bcd_stream.sv
// Directed bench for ex3_to_bcd_stream (NDIG=4): packing, backpressure, invalid codes, reset and flush.
module tb_ex3_to_bcd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ex3;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic        bad_digit;

  int n_chk = 0;
  int n_err = 0;

  ex3_to_bcd_stream #(.NDIG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ex3    (in_ex3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one digit at a falling edge; it transfers on the next rising edge.
  task automatic send_digit(input logic [3:0] code);
    in_valid = 1'b1;
    in_ex3   = code;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3);
    send_digit(c0);
    send_digit(c1);
    send_digit(c2);
    chk("no_valid_before_last", 32'(out_valid), 32'd0);
    send_digit(c3);
  endtask

  task automatic take_word();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop_after_take", 32'(out_valid), 32'd0);
    chk("ready_after_take", 32'(in_ready), 32'd1);
    chk("err_clear_after_take", 32'(out_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_ex3    = 4'h0;
    out_ready = 1'b0;

    // 1: reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0000);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_bad_digit", 32'(bad_digit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 2: basic word, valid one cycle after 4th digit
    send_word(4'h4, 4'h6, 4'h8, 4'hC);
    chk("w1_valid", 32'(out_valid), 32'd1);
    chk("w1_data", 32'(out_data), 32'h1359);
    chk("w1_err", 32'(out_err), 32'd0);
    chk("w1_in_ready", 32'(in_ready), 32'd0);
    chk("w1_bad", 32'(bad_digit), 32'd0);

    // 3: backpressure; a digit offered during HOLD must wait
    in_valid = 1'b1;
    in_ex3   = 4'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data_stable", 32'(out_data), 32'h1359);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    send_word(4'h5, 4'h6, 4'h7, 4'h8);
    chk("held_digit_word", 32'(out_data), 32'h2345);
    chk("held_digit_valid", 32'(out_valid), 32'd1);
    take_word();

    // 4: invalid code in the stream
    send_digit(4'h4);
    chk("bad_idle", 32'(bad_digit), 32'd0);
    send_digit(4'h1);
    chk("bad_pulse", 32'(bad_digit), 32'd1);
    send_digit(4'h8);
    chk("bad_one_cycle", 32'(bad_digit), 32'd0);
    send_digit(4'hC);
`ifdef EX3_DROP_INVALID_EN
    chk("drop_not_full", 32'(out_valid), 32'd0);
    send_digit(4'h3);
    chk("drop_valid", 32'(out_valid), 32'd1);
    chk("drop_data", 32'(out_data), 32'h1590);
    chk("drop_err", 32'(out_err), 32'd0);
`else
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_data", 32'(out_data), 32'h1F59);
    chk("sub_err", 32'(out_err), 32'd1);
`endif
    take_word();

    // 5: async reset mid-word discards the partial word
    send_digit(4'h4);
    send_digit(4'h6);
    #2;
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(4'hC, 4'hC, 4'h3, 4'h3);
    chk("midrst_word", 32'(out_data), 32'h9900);
    chk("midrst_word_valid", 32'(out_valid), 32'd1);
    take_word();

    // 6: flush on the 3rd digit (invalid code, so bad_digit must stay low)
    send_digit(4'h4);
    send_digit(4'h5);
    clr = 1'b1;
    send_digit(4'h0);
    clr = 1'b0;
    chk("clr_no_bad", 32'(bad_digit), 32'd0);
    chk("clr_no_valid", 32'(out_valid), 32'd0);
    send_word(4'h7, 4'h8, 4'h9, 4'hA);
    chk("clr_word", 32'(out_data), 32'h4567);
    chk("clr_word_err", 32'(out_err), 32'd0);
    chk("clr_word_valid", 32'(out_valid), 32'd1);
    // flush during HOLD
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_hold_valid", 32'(out_valid), 32'd0);
    chk("clr_hold_ready", 32'(in_ready), 32'd1);
    send_word(4'h3, 4'h4, 4'h5, 4'h6);
    chk("post_clr_word", 32'(out_data), 32'h0123);
    take_word();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
